// File: rtl/spinner_pkg.sv
// Shared encodings for the multi-channel spinner/position generator.
package spinner_pkg;

  localparam logic [1:0] MODE_WRAP   = 2'b00;
  localparam logic [1:0] MODE_SPIN   = 2'b01;
  localparam logic [1:0] MODE_CLAMP  = 2'b10;
  localparam logic [1:0] MODE_CENTER = 2'b11;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOLD_PLUS  = 2'd1,
    HOLD_MINUS = 2'd2
  } spin_state_t;

endpackage

// File: rtl/spinner_multi_if.sv
// Control/position bundle between the emu top level and spinner_multi.
interface spinner_multi_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
);

  logic                      strobe;
  logic [CHANNELS-1:0]       plus;
  logic [CHANNELS-1:0]       minus;
  logic [2*CHANNELS-1:0]     mode;
  logic [CHANNELS-1:0]       delta_valid;
  logic [8*CHANNELS-1:0]     delta;
  logic [WIDTH*CHANNELS-1:0] angle;
  logic [CHANNELS-1:0]       moved;

  modport master (
    output strobe, plus, minus, mode, delta_valid, delta,
    input  angle, moved
  );

  modport slave (
    input  strobe, plus, minus, mode, delta_valid, delta,
    output angle, moved
  );

endinterface

// File: rtl/spinner_chan.sv
// One position channel: button hold/acceleration FSM, wrap/clamp/centering
// arithmetic and spinner delta accumulation. The frame tick comes from the top.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no single button held (also forced in spinner mode)
// HOLD_PLUS  | plus alone held on the last tick, hold_q counts frames
// HOLD_MINUS | minus alone held on the last tick, hold_q counts frames
module spinner_chan
  import spinner_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 8,
  parameter int ACCEL_SHIFT = 2,
  parameter int HOLD_MAX    = 63,
  parameter int CENTER      = 2**(WIDTH-1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             plus,
  input  logic             minus,
  input  logic [1:0]       mode,
  input  logic             delta_valid,
  input  logic [7:0]       delta,
  output logic [WIDTH-1:0] angle,
  output logic             moved
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [WIDTH:0]   MAX_ANGLE  = (WIDTH+1)'((1 << WIDTH) - 1);
  localparam logic [WIDTH:0]   STEP_MIN_W = (WIDTH+1)'(STEP_MIN);
  localparam logic [WIDTH:0]   STEP_MAX_W = (WIDTH+1)'(STEP_MAX);
  localparam logic [HW-1:0]    HOLD_MAX_W = HW'(HOLD_MAX);
  localparam logic [WIDTH-1:0] CENTER_W   = WIDTH'(CENTER);

  spin_state_t      state_q, state_n, tgt;
  logic [HW-1:0]    hold_q, hold_n;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] angle_n;
  logic             moved_n;
  logic [WIDTH:0]   step, accel, sum, ext_angle;
  logic [WIDTH-1:0] dext;

  // Register FSM state, hold counter, position and the mode snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      mode_q  <= MODE_WRAP;
      angle   <= CENTER_W;
      moved   <= 1'b0;
    end else begin
      state_q <= state_n;
      hold_q  <= hold_n;
      mode_q  <= mode;
      angle   <= angle_n;
      moved   <= moved_n;
    end
  end

  // Next state and next position; a mode change wins over any event that cycle.
  always_comb begin
    state_n   = state_q;
    hold_n    = hold_q;
    angle_n   = angle;
    moved_n   = 1'b0;
    tgt       = IDLE;
    accel     = '0;
    step      = STEP_MIN_W;
    sum       = '0;
    ext_angle = {1'b0, angle};
    dext      = WIDTH'($signed(delta));

    if (mode != mode_q) begin
      state_n = IDLE;
      hold_n  = '0;
    end else if (mode == MODE_SPIN) begin
      state_n = IDLE;
      hold_n  = '0;
      if (delta_valid) begin
        angle_n = angle + dext;
        moved_n = (delta != 8'd0);
      end
    end else if (tick) begin
      if (plus && !minus)      tgt = HOLD_PLUS;
      else if (minus && !plus) tgt = HOLD_MINUS;
      else                     tgt = IDLE;
      state_n = tgt;

      // Re-entering a hold restarts acceleration so the first step is STEP_MIN.
      if (tgt == IDLE || tgt != state_q) hold_n = '0;
      else if (hold_q != HOLD_MAX_W)     hold_n = hold_q + 1'b1;

      accel = (WIDTH+1)'(hold_n >> ACCEL_SHIFT);
      step  = STEP_MIN_W + accel;
      if (step > STEP_MAX_W) step = STEP_MAX_W;

      case (tgt)
        HOLD_PLUS: begin
          if (mode == MODE_WRAP) begin
            angle_n = angle + step[WIDTH-1:0];
          end else begin
            sum     = ext_angle + step;
            angle_n = (sum > MAX_ANGLE) ? MAX_ANGLE[WIDTH-1:0] : sum[WIDTH-1:0];
          end
        end
        HOLD_MINUS: begin
          if (mode == MODE_WRAP) begin
            angle_n = angle - step[WIDTH-1:0];
          end else begin
            sum     = ext_angle - step;
            angle_n = (step > ext_angle) ? '0 : sum[WIDTH-1:0];
          end
        end
        default: begin
          if (mode == MODE_CENTER) begin
            if (angle > CENTER_W) begin
              sum     = ext_angle - {1'b0, CENTER_W};
              angle_n = (sum <= STEP_MAX_W) ? CENTER_W : angle - STEP_MAX_W[WIDTH-1:0];
            end else if (angle < CENTER_W) begin
              sum     = {1'b0, CENTER_W} - ext_angle;
              angle_n = (sum <= STEP_MAX_W) ? CENTER_W : angle + STEP_MAX_W[WIDTH-1:0];
            end
          end
        end
      endcase
      moved_n = (angle_n != angle);
    end
  end

endmodule

// File: rtl/spinner_multi.sv
// Multi-channel rotary/positional input generator. Holds the frame strobe
// edge detector and fans the interface vectors out to per-channel instances.
module spinner_multi
  import spinner_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 8,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 8,
  parameter int ACCEL_SHIFT = 2,
  parameter int HOLD_MAX    = 63,
  parameter int CENTER      = 2**(WIDTH-1)
) (
  input  logic            clk,
  input  logic            reset_n,
  spinner_multi_if.slave  bus
);

  logic strobe_d;
  logic tick;

  // Delayed strobe; resets high so a strobe already high at release is not a tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) strobe_d <= 1'b1;
    else          strobe_d <= bus.strobe;
  end

  assign tick = bus.strobe & ~strobe_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    spinner_chan #(
      .WIDTH       (WIDTH),
      .STEP_MIN    (STEP_MIN),
      .STEP_MAX    (STEP_MAX),
      .ACCEL_SHIFT (ACCEL_SHIFT),
      .HOLD_MAX    (HOLD_MAX),
      .CENTER      (CENTER)
    ) u_chan (
      .clk         (clk),
      .reset_n     (reset_n),
      .tick        (tick),
      .plus        (bus.plus[g]),
      .minus       (bus.minus[g]),
      .mode        (bus.mode[2*g +: 2]),
      .delta_valid (bus.delta_valid[g]),
      .delta       (bus.delta[8*g +: 8]),
      .angle       (bus.angle[WIDTH*g +: WIDTH]),
      .moved       (bus.moved[g])
    );
  end

endmodule
